// File: rtl/rs_alu_exec.sv
// ----------------------------------------------------------------------------
// rs_alu_exec
//   Single-stage RV32I integer/branch execution pipe on the RS issue port.
//   Accepts one decoded op per cycle with no backpressure, computes the rd
//   value, resolves the control-transfer outcome and registers the result
//   onto the RS CDB one cycle later.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   rdy                      global ready; low freezes every register
//   rollback_flag_from_rob   misprediction flush; drops the current broadcast
//   openum_from_rs           issued op (`OPENUM_NOP = no op)
//   V1_from_rs, V2_from_rs   rs1 / rs2 values
//   pc_from_rs, imm_from_rs  instruction PC and sign-extended immediate
//   rob_id_from_rs           destination ROB tag
//   valid_to_cdb, rob_id_to_cdb, result_to_cdb,
//   target_pc_to_cdb, jump_flag_to_cdb   registered CDB broadcast
//
// Optional build macro
//   RS_ALU_PERF_CNT_EN  adds perf_exec_cnt / perf_branch_cnt / perf_taken_cnt
//                       (reset by rst only, hold under ~rdy, wrap at 2^32).
//   DEBUG               prints the code of any unsupported op that is dropped.
// ----------------------------------------------------------------------------

`ifndef OPENUM_NOP
`define OPENUM_TYPE  logic [5:0]
`define DATA_TYPE    logic [31:0]
`define ADDR_TYPE    logic [31:0]
`define ROB_ID_TYPE  logic [3:0]
`define ZERO_ROB     4'd0
`define OPENUM_NOP   6'd0
`define OPENUM_LUI   6'd1
`define OPENUM_AUIPC 6'd2
`define OPENUM_JAL   6'd3
`define OPENUM_JALR  6'd4
`define OPENUM_BEQ   6'd5
`define OPENUM_BNE   6'd6
`define OPENUM_BLT   6'd7
`define OPENUM_BGE   6'd8
`define OPENUM_BLTU  6'd9
`define OPENUM_BGEU  6'd10
`define OPENUM_LB    6'd11
`define OPENUM_LH    6'd12
`define OPENUM_LW    6'd13
`define OPENUM_LBU   6'd14
`define OPENUM_LHU   6'd15
`define OPENUM_SB    6'd16
`define OPENUM_SH    6'd17
`define OPENUM_SW    6'd18
`define OPENUM_ADDI  6'd19
`define OPENUM_SLTI  6'd20
`define OPENUM_SLTIU 6'd21
`define OPENUM_XORI  6'd22
`define OPENUM_ORI   6'd23
`define OPENUM_ANDI  6'd24
`define OPENUM_SLLI  6'd25
`define OPENUM_SRLI  6'd26
`define OPENUM_SRAI  6'd27
`define OPENUM_ADD   6'd28
`define OPENUM_SUB   6'd29
`define OPENUM_SLL   6'd30
`define OPENUM_SLT   6'd31
`define OPENUM_SLTU  6'd32
`define OPENUM_XOR   6'd33
`define OPENUM_SRL   6'd34
`define OPENUM_SRA   6'd35
`define OPENUM_OR    6'd36
`define OPENUM_AND   6'd37
`endif

module rs_alu_exec #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rdy,
   input  logic          rollback_flag_from_rob,
   input  `OPENUM_TYPE   openum_from_rs,
   input  `DATA_TYPE     V1_from_rs,
   input  `DATA_TYPE     V2_from_rs,
   input  `ADDR_TYPE     pc_from_rs,
   input  `DATA_TYPE     imm_from_rs,
   input  `ROB_ID_TYPE   rob_id_from_rs,
   output logic          valid_to_cdb,
   output `ROB_ID_TYPE   rob_id_to_cdb,
   output `DATA_TYPE     result_to_cdb,
   output `ADDR_TYPE     target_pc_to_cdb,
   output logic          jump_flag_to_cdb
`ifdef RS_ALU_PERF_CNT_EN
   ,
   output logic [31:0]   perf_exec_cnt,
   output logic [31:0]   perf_branch_cnt,
   output logic [31:0]   perf_taken_cnt
`endif
);

   // ------------------------------------------------------------------
   // Combinational execute
   // ------------------------------------------------------------------
   logic [XLEN-1:0]    v1, v2, pc, imm;
   logic [XLEN-1:0]    pc_plus4, pc_plus_imm;
   logic [SHAMT_W-1:0] shamt_r, shamt_i;

   logic            ex_vld_d;
   logic [XLEN-1:0] ex_res_d;
   logic [XLEN-1:0] ex_tgt_d;
   logic            ex_jmp_d;
   logic            br_taken;
   logic            is_branch;

   assign v1          = V1_from_rs;
   assign v2          = V2_from_rs;
   assign pc          = pc_from_rs;
   assign imm         = imm_from_rs;
   assign pc_plus4    = pc + XLEN'(4);
   assign pc_plus_imm = pc + imm;
   assign shamt_r     = v2[SHAMT_W-1:0];
   assign shamt_i     = imm[SHAMT_W-1:0];

   // Branch condition; only meaningful when is_branch is set.
   always_comb begin
      br_taken  = 1'b0;
      is_branch = 1'b1;
      case (openum_from_rs)
         `OPENUM_BEQ:  br_taken = (v1 == v2);
         `OPENUM_BNE:  br_taken = (v1 != v2);
         `OPENUM_BLT:  br_taken = ($signed(v1) <  $signed(v2));
         `OPENUM_BGE:  br_taken = ($signed(v1) >= $signed(v2));
         `OPENUM_BLTU: br_taken = (v1 <  v2);
         `OPENUM_BGEU: br_taken = (v1 >= v2);
         default:      is_branch = 1'b0;
      endcase
   end

   always_comb begin
      ex_vld_d = 1'b1;
      ex_res_d = '0;
      ex_tgt_d = pc_plus4;
      ex_jmp_d = 1'b0;
      case (openum_from_rs)
         `OPENUM_ADD:   ex_res_d = v1 + v2;
         `OPENUM_ADDI:  ex_res_d = v1 + imm;
         `OPENUM_SUB:   ex_res_d = v1 - v2;
         `OPENUM_AND:   ex_res_d = v1 & v2;
         `OPENUM_ANDI:  ex_res_d = v1 & imm;
         `OPENUM_OR:    ex_res_d = v1 | v2;
         `OPENUM_ORI:   ex_res_d = v1 | imm;
         `OPENUM_XOR:   ex_res_d = v1 ^ v2;
         `OPENUM_XORI:  ex_res_d = v1 ^ imm;
         `OPENUM_SLL:   ex_res_d = v1 << shamt_r;
         `OPENUM_SLLI:  ex_res_d = v1 << shamt_i;
         `OPENUM_SRL:   ex_res_d = v1 >> shamt_r;
         `OPENUM_SRLI:  ex_res_d = v1 >> shamt_i;
         `OPENUM_SRA:   ex_res_d = XLEN'($signed(v1) >>> shamt_r);
         `OPENUM_SRAI:  ex_res_d = XLEN'($signed(v1) >>> shamt_i);
         `OPENUM_SLT:   ex_res_d = XLEN'($signed(v1) < $signed(v2));
         `OPENUM_SLTI:  ex_res_d = XLEN'($signed(v1) < $signed(imm));
         `OPENUM_SLTU:  ex_res_d = XLEN'(v1 < v2);
         `OPENUM_SLTIU: ex_res_d = XLEN'(v1 < imm);
         `OPENUM_LUI:   ex_res_d = imm;
         `OPENUM_AUIPC: ex_res_d = pc_plus_imm;
         `OPENUM_JAL: begin
            ex_res_d = pc_plus4;
            ex_tgt_d = pc_plus_imm;
            ex_jmp_d = 1'b1;
         end
         `OPENUM_JALR: begin
            ex_res_d = pc_plus4;
            ex_tgt_d = (v1 + imm) & ~XLEN'(1);
            ex_jmp_d = 1'b1;
         end
         `OPENUM_BEQ, `OPENUM_BNE, `OPENUM_BLT,
         `OPENUM_BGE, `OPENUM_BLTU, `OPENUM_BGEU: begin
            ex_tgt_d = br_taken ? pc_plus_imm : pc_plus4;
            ex_jmp_d = br_taken;
         end
         // NOP, loads, stores and undefined codes produce no broadcast.
         default:       ex_vld_d = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // CDB output registers
   // ------------------------------------------------------------------
   logic            valid_q;
   `ROB_ID_TYPE     rob_q;
   logic [XLEN-1:0] res_q;
   logic [XLEN-1:0] tgt_q;
   logic            jmp_q;

   always_ff @(posedge clk) begin
      if (rst || rollback_flag_from_rob) begin
         valid_q <= 1'b0;
         rob_q   <= `ZERO_ROB;
         res_q   <= '0;
         tgt_q   <= '0;
         jmp_q   <= 1'b0;
      end else if (rdy) begin
         valid_q <= ex_vld_d;
         // A dropped op leaves the payload of the last broadcast in place.
         if (ex_vld_d) begin
            rob_q <= rob_id_from_rs;
            res_q <= ex_res_d;
            tgt_q <= ex_tgt_d;
            jmp_q <= ex_jmp_d;
         end
      end
   end

   assign valid_to_cdb     = valid_q;
   assign rob_id_to_cdb    = rob_q;
   assign result_to_cdb    = res_q;
   assign target_pc_to_cdb = tgt_q;
   assign jump_flag_to_cdb = jmp_q;

`ifdef DEBUG
   always_ff @(posedge clk) begin
      if (!rst && !rollback_flag_from_rob && rdy && !ex_vld_d &&
          openum_from_rs != `OPENUM_NOP)
         $display("rs_alu_exec: unsupported openum %0d dropped", openum_from_rs);
   end
`endif

   // ------------------------------------------------------------------
   // Performance counters: bumped on the edge that launches a broadcast,
   // so an op frozen on the CDB by ~rdy is counted only once.
   // ------------------------------------------------------------------
`ifdef RS_ALU_PERF_CNT_EN
   logic [31:0] exec_cnt_q, branch_cnt_q, taken_cnt_q;
   logic        launch;
   logic        is_ctrl;

   assign launch  = rdy && !rollback_flag_from_rob && ex_vld_d;
   assign is_ctrl = is_branch || openum_from_rs == `OPENUM_JAL ||
                    openum_from_rs == `OPENUM_JALR;

   always_ff @(posedge clk) begin
      if (rst) begin
         exec_cnt_q   <= '0;
         branch_cnt_q <= '0;
         taken_cnt_q  <= '0;
      end else if (launch) begin
         exec_cnt_q <= exec_cnt_q + 32'd1;
         if (is_ctrl)  branch_cnt_q <= branch_cnt_q + 32'd1;
         if (ex_jmp_d) taken_cnt_q  <= taken_cnt_q + 32'd1;
      end
   end

   assign perf_exec_cnt   = exec_cnt_q;
   assign perf_branch_cnt = branch_cnt_q;
   assign perf_taken_cnt  = taken_cnt_q;
`else
   logic unused_branch;
   assign unused_branch = is_branch;
`endif

endmodule

// File: doc/rs_alu_exec.md
Name: rs_alu_exec

Overview:
- Execution-side consumer of the RS issue port. It takes one decoded RV32I integer or branch op per cycle, computes the result, resolves the branch or jump outcome, and broadcasts it on the RS CDB.
- It sits between the reservation station and the CDB consumers: ROB, RS, LSB and register file.
- It has no backpressure. The RS may issue every cycle and this block must accept every cycle.
- It is a registered single-stage execution pipe with rollback flush and rdy hold.

Parameters:
- XLEN, 32, datapath width; must match `DATA_TYPE.
- SHAMT_W, 5, shift-amount width taken from the low bits of the operand.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global ready; low freezes all state.
- rollback_flag_from_rob  in  1  ROB misprediction flush.
- openum_from_rs  in  `OPENUM_TYPE  issued op; `OPENUM_NOP means no op.
- V1_from_rs  in  `DATA_TYPE  rs1 value.
- V2_from_rs  in  `DATA_TYPE  rs2 value.
- pc_from_rs  in  `ADDR_TYPE  instruction PC.
- imm_from_rs  in  `DATA_TYPE  sign-extended immediate.
- rob_id_from_rs  in  `ROB_ID_TYPE  destination ROB entry.
- valid_to_cdb  out  1  broadcast valid.
- rob_id_to_cdb  out  `ROB_ID_TYPE  broadcast tag.
- result_to_cdb  out  `DATA_TYPE  rd value.
- target_pc_to_cdb  out  `ADDR_TYPE  resolved next PC, for control ops.
- jump_flag_to_cdb  out  1  control transfer taken.

Behaviour:
- Reset and rollback have priority, in this order: rst, then rollback, then ~rdy, then normal.
  - On rst or rollback, at the edge: valid_to_cdb=0, rob_id_to_cdb=`ZERO_ROB, result_to_cdb=0, target_pc_to_cdb=0, jump_flag_to_cdb=0.
  - The op presented in that cycle is discarded.
- ~rdy: all output registers hold their values. A CDB valid that is already asserted stays asserted.
- Latency: an op sampled at edge N is broadcast in the cycle after edge N. valid_to_cdb is high for exactly one cycle per op, unless rdy is low.
- openum_from_rs==`OPENUM_NOP at an edge: valid_to_cdb<=0. The other outputs hold.
- Result rules, with all arithmetic mod 2^32:
  - ADD/ADDI: V1+(V2|imm). SUB: V1-V2.
  - AND/OR/XOR and their I-forms: bitwise.
  - SLL/SRL/SRA: shift amount is V2[4:0]. For the I-forms the shift amount is imm[4:0]. SRA is arithmetic.
  - SLT/SLTI: signed compare, result 1 or 0. SLTU/SLTIU: unsigned compare. SLTIU compares against the sign-extended imm, treated as unsigned.
  - LUI: imm. AUIPC: pc+imm.
  - For all of the above: jump_flag=0, target_pc=pc+4.
- JAL:
  - result=pc+4, target=pc+imm, jump=1.
- JALR:
  - result=pc+4, target=(V1+imm)&~1, jump=1.
- Branches (BEQ, BNE, BLT, BGE, BLTU, BGEU):
  - result=0.
  - jump=condition; BLT/BGE compare signed, BLTU/BGEU compare unsigned.
  - target=pc+imm if taken, else pc+4.
  - The ROB compares jump_flag against its prediction. This block does not hold a prediction.
- Unsupported openums (loads, stores, or undefined codes): treated as NOP, valid<=0. Under DEBUG, $display the code.
- Back-to-back issue: a new op every cycle yields a valid broadcast every cycle. There are no bubbles and no internal queue.
- Rollback asserted while valid_to_cdb=1: valid drops at that edge. The stale broadcast is not repeated.
- Overflow is ignored. No exceptions are raised.

Optional Feature:
- Macro: RS_ALU_PERF_CNT_EN.
- Defined: adds three 32-bit outputs.
  - perf_exec_cnt: number of valid broadcasts.
  - perf_branch_cnt: number of control ops broadcast.
  - perf_taken_cnt: number of broadcasts with jump_flag=1.
  - All three reset on rst only; rollback does not reset them.
  - They hold under ~rdy and wrap at 2^32.
- Undefined: these ports and registers do not exist. The rest of the behaviour is identical.

Test Plan:
- ADD, V1=0x7FFFFFFF, V2=1, rob=3 -> next cycle: valid=1, rob=3, result=0x80000000, jump=0, target=pc+4; the following cycle (NOP): valid=0.
- SLT and SLTU, V1=0xFFFFFFFF, V2=1, issued back-to-back -> two consecutive valid cycles with results 1 then 0. SRAI with imm=0x404 on V1=0x80000000 -> 0xF8000000, using shamt 4.
- BEQ, pc=0x100, V1=V2=5, imm=-8 -> jump=1, target=0xF8, result=0. BNE with the same inputs -> jump=0, target=0x104.
- JALR, pc=0x200, V1=0x1001, imm=2 -> result=0x204, target=0x1002, jump=1.
- ADD issued, then rollback_flag high in the next cycle with BEQ presented -> valid=0 after the rollback edge; the BEQ is never broadcast.
- ADD issued with rdy low for 3 cycles after the result edge -> valid, rob and result held for the 3 cycles. With RS_ALU_PERF_CNT_EN, perf_exec_cnt increments once only.
